ritc_corr_cfg_sequencer: RTL and testbench



---
 rtl/ritc_corr_cfg_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_ritc_corr_cfg_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ritc_corr_cfg_sequencer.sv
// ritc_corr_cfg_sequencer: queues pedestal and DINL commands from the
// user register bus and plays them onto the quadcorr config buses.
module ritc_corr_cfg_sequencer #(
  parameter int DINL_DEPTH     = 64,
  parameter int PED_RST_CYCLES = 4,
  parameter int UPD_GAP        = 3
) (
  input  logic        user_clk_i,
  input  logic        user_rst_n_i,
  input  logic        user_sel_i,
  input  logic        user_wr_i,
  input  logic [2:0]  user_addr_i,
  input  logic [31:0] user_dat_i,
  output logic [31:0] user_dat_o,
  output logic        ped_rst_o,
  output logic [4:0]  ped_addr_o,
  output logic [47:0] ped_o,
  output logic        ped_update_o,
  output logic [31:0] dinl_cdi_o,
  output logic        dinl_ce_o,
  output logic        busy_o
);
  localparam int AW = $clog2(DINL_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0] RST_LAST = 8'(PED_RST_CYCLES - 1);
  localparam logic [7:0] UPD_LAST = 8'(UPD_GAP);
  localparam logic [PW-1:0] PTR_FULL = PW'(DINL_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_UPD  = 2'd2,
    S_DINL = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [47:0]     stg_dat_q, stg_dat_d;
  logic [4:0]      stg_adr_q, stg_adr_d;
  logic [47:0]     ped_q, ped_d;
  logic [4:0]      ped_adr_q, ped_adr_d;
  logic            pend_rst_q, pend_rst_d;
  logic            pend_upd_q, pend_upd_d;
  logic            pend_dinl_q, pend_dinl_d;
  logic            err_dup_q, err_dup_d;
  logic            err_ovf_q, err_ovf_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     mem_q [DINL_DEPTH];

  logic we, wr_lo, wr_hi, wr_ctrl, wr_data;
  logic go_rst, go_upd, go_dinl, ptr_clr, err_clr;
  logic in_dinl, full, mem_we;
  logic leave, take_rst, take_upd, take_dinl;
  logic [7:0] wptr8;

  assign we      = user_sel_i & user_wr_i;
  assign wr_lo   = we & (user_addr_i == 3'd0);
  assign wr_hi   = we & (user_addr_i == 3'd1);
  assign wr_ctrl = we & (user_addr_i == 3'd2);
  assign wr_data = we & (user_addr_i == 3'd3);

  assign go_rst  = wr_ctrl & user_dat_i[0];
  assign go_upd  = wr_ctrl & user_dat_i[1];
  assign go_dinl = wr_ctrl & user_dat_i[2];
  assign ptr_clr = wr_ctrl & user_dat_i[3];
  assign err_clr = wr_ctrl & user_dat_i[4];

  assign in_dinl = (state_q == S_DINL);
  assign full    = (wptr_q == PTR_FULL);
  assign mem_we  = wr_data & ~in_dinl & ~full;
  assign wptr8   = 8'(wptr_q);

  // Last cycle of the current state; IDLE may always dispatch.
  always_comb begin
    leave = 1'b0;
    unique case (state_q)
      S_IDLE: leave = 1'b1;
      S_RST:  leave = (cnt_q == RST_LAST);
      S_UPD:  leave = (cnt_q == UPD_LAST);
      S_DINL: leave = ((cnt_q + 8'd1) >= wptr8);
    endcase
  end

  assign take_rst  = leave & pend_rst_q;
  assign take_upd  = leave & ~pend_rst_q & pend_upd_q;
  assign take_dinl = leave & ~pend_rst_q & ~pend_upd_q
                   & pend_dinl_q;

  // Next state: chain straight into the next pending command.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    if (take_rst) begin
      state_d = S_RST;
      cnt_d   = '0;
    end else if (take_upd) begin
      state_d = S_UPD;
      cnt_d   = '0;
    end else if (take_dinl) begin
      state_d = S_DINL;
      cnt_d   = '0;
    end else if (leave) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Bus outputs decoded from state and cycle count.
  always_comb begin
    ped_rst_o    = (state_q == S_RST);
    ped_update_o = (state_q == S_UPD) & (cnt_q == 8'd0);
    dinl_ce_o    = in_dinl & (cnt_q < wptr8);
    dinl_cdi_o   = '0;
    if (dinl_ce_o) dinl_cdi_o = mem_q[cnt_q[AW-1:0]];
  end

  assign busy_o = (state_q != S_IDLE) | pend_rst_q
                | pend_upd_q | pend_dinl_q;
  assign ped_o      = ped_q;
  assign ped_addr_o = ped_adr_q;
  assign user_dat_o = dat_q;

  // Staging, command queue, error flags and readback mux.
  always_comb begin
    stg_dat_d = stg_dat_q;
    stg_adr_d = stg_adr_q;
    if (wr_lo) stg_dat_d[31:0] = user_dat_i;
    if (wr_hi) begin
      stg_dat_d[47:32] = user_dat_i[15:0];
      stg_adr_d        = user_dat_i[20:16];
    end

    pend_rst_d  = (pend_rst_q & ~take_rst) | go_rst;
    pend_upd_d  = (pend_upd_q & ~take_upd) | go_upd;
    pend_dinl_d = (pend_dinl_q & ~take_dinl) | go_dinl;

    err_dup_d = err_dup_q & ~err_clr;
    err_ovf_d = err_ovf_q & ~err_clr;
    if ((go_rst & pend_rst_q & ~take_rst)
      | (go_upd & pend_upd_q & ~take_upd)
      | (go_dinl & pend_dinl_q & ~take_dinl)
      | (wr_data & in_dinl))
      err_dup_d = 1'b1;
    if (wr_data & ~in_dinl & full)
      err_ovf_d = 1'b1;

    wptr_d = wptr_q;
    if (ptr_clr) wptr_d = '0;
    else if (mem_we) wptr_d = wptr_q + 1'b1;

    ped_d     = ped_q;
    ped_adr_d = ped_adr_q;
    if (take_upd) begin
      ped_d     = stg_dat_q;
      ped_adr_d = stg_adr_q;
    end

    unique case (user_addr_i)
      3'd0: dat_d = stg_dat_q[31:0];
      3'd1: dat_d = {11'b0, stg_adr_q, stg_dat_q[47:32]};
      3'd2: dat_d = {16'b0, wptr8, busy_o, err_ovf_q,
                     err_dup_q, pend_dinl_q, pend_upd_q,
                     pend_rst_q, state_q};
      default: dat_d = '0;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge user_clk_i) begin
    if (!user_rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stg_dat_q   <= '0;
      stg_adr_q   <= '0;
      ped_q       <= '0;
      ped_adr_q   <= '0;
      pend_rst_q  <= 1'b0;
      pend_upd_q  <= 1'b0;
      pend_dinl_q <= 1'b0;
      err_dup_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      wptr_q      <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stg_dat_q   <= stg_dat_d;
      stg_adr_q   <= stg_adr_d;
      ped_q       <= ped_d;
      ped_adr_q   <= ped_adr_d;
      pend_rst_q  <= pend_rst_d;
      pend_upd_q  <= pend_upd_d;
      pend_dinl_q <= pend_dinl_d;
      err_dup_q   <= err_dup_d;
      err_ovf_q   <= err_ovf_d;
      wptr_q      <= wptr_d;
      dat_q       <= dat_d;
    end
  end

  // DINL playout buffer; contents survive reset.
  always_ff @(posedge user_clk_i) begin
    if (mem_we) mem_q[wptr_q[AW-1:0]] <= user_dat_i;
  end
endmodule

// File: tb/tb_ritc_corr_cfg_sequencer.sv
// tb_ritc_corr_cfg_sequencer: register vectors plus scoreboarded
// pedestal and DINL command sequences.
module tb_ritc_corr_cfg_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        wr;
  logic [2:0]  addr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ped_rst;
  logic [4:0]  ped_addr;
  logic [47:0] ped;
  logic        ped_upd;
  logic [31:0] cdi;
  logic        ce;
  logic        busy;

  ritc_corr_cfg_sequencer dut (
    .user_clk_i   (clk),
    .user_rst_n_i (rst_n),
    .user_sel_i   (sel),
    .user_wr_i    (wr),
    .user_addr_i  (addr),
    .user_dat_i   (wdat),
    .user_dat_o   (rdat),
    .ped_rst_o    (ped_rst),
    .ped_addr_o   (ped_addr),
    .ped_o        (ped),
    .ped_update_o (ped_upd),
    .dinl_cdi_o   (cdi),
    .dinl_ce_o    (ce),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  int nvec = 0;
  int nerr = 0;
  int ce_cnt = 0;
  int upd_cnt = 0;
  logic [31:0] dinl_q [$];
  logic [52:0] upd_q [$];
  logic [31:0] words [4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    logic [31:0] w;
    logic [52:0] e;
    @(negedge clk);
    if (ce) begin
      ce_cnt++;
      if (dinl_q.size() == 0) begin
        chk("dinl_unexpected_ce", 64'(ce), 64'(0));
      end else begin
        w = dinl_q.pop_front();
        chk("dinl_word", 64'(cdi), 64'(w));
      end
    end
    if (ped_upd) begin
      upd_cnt++;
      if (upd_q.size() == 0) begin
        chk("ped_unexpected_update", 64'(ped_upd), 64'(0));
      end else begin
        e = upd_q.pop_front();
        chk("ped_word", 64'(ped), 64'(e[47:0]));
        chk("ped_addr", 64'(ped_addr), 64'(e[52:48]));
      end
    end
  endtask

  task automatic wreg(input logic [2:0] a, input logic [31:0] d);
    sel  = 1'b1;
    wr   = 1'b1;
    addr = a;
    wdat = d;
    step();
    sel  = 1'b0;
    wr   = 1'b0;
  endtask

  task automatic rreg(input logic [2:0] a, output logic [31:0] v);
    addr = a;
    step();
    v = rdat;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] x;
    vt[0] = '{1'b0, 3'd0, 32'h0, 3'd2, 32'h0};
    vt[1] = '{1'b0, 3'd0, 32'h0, 3'd0, 32'h0};
    vt[2] = '{1'b1, 3'd0, 32'hDEADBEEF, 3'd0, 32'hDEADBEEF};
    vt[3] = '{1'b1, 3'd1, 32'hFFFFFFFF, 3'd1, 32'h001FFFFF};
    vt[4] = '{1'b1, 3'd1, 32'h001A1234, 3'd1, 32'h001A1234};
    vt[5] = '{1'b1, 3'd5, 32'hAAAAAAAA, 3'd0, 32'hDEADBEEF};
    vt[6] = '{1'b0, 3'd0, 32'h0, 3'd3, 32'h0};
    vt[7] = '{1'b0, 3'd0, 32'h0, 3'd7, 32'h0};
    vt[8] = '{1'b1, 3'd4, 32'h55555555, 3'd1, 32'h001A1234};
    vt[9] = '{1'b1, 3'd2, 32'h00000008, 3'd2, 32'h0};

    rst_n = 1'b0;
    sel   = 1'b0;
    wr    = 1'b0;
    addr  = 3'd0;
    wdat  = 32'h0;
    run(3);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ped", 64'(ped), 64'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      if (vt[i].w) wreg(vt[i].wa, vt[i].wd);
      rreg(vt[i].ra, r);
      chk($sformatf("vec%0d", i), 64'(r), 64'(vt[i].exp));
    end

    // Single pedestal update with a staging write in the gap.
    upd_cnt = 0;
    upd_q.push_back({5'h1A, 48'h1234DEADBEEF});
    wreg(3'd2, 32'h2);
    step();
    chk("upd_latency", 64'(ped_upd), 64'(1));
    wreg(3'd0, 32'h01234567);
    chk("upd_gap1_upd", 64'(ped_upd), 64'(0));
    chk("upd_gap1_busy", 64'(busy), 64'(1));
    chk("upd_hold", 64'(ped), 64'h1234DEADBEEF);
    step();
    chk("upd_gap2_busy", 64'(busy), 64'(1));
    step();
    chk("upd_gap3_busy", 64'(busy), 64'(1));
    step();
    chk("upd_done_busy", 64'(busy), 64'(0));
    chk("upd_pulses", 64'(upd_cnt), 64'(1));
    chk("upd_hold_idle", 64'(ped), 64'h1234DEADBEEF);

    // Combined RST + UPD + DINL in one CTRL write.
    wreg(3'd2, 32'h8);
    for (int i = 0; i < 3; i++) begin
      x = $urandom;
      dinl_q.push_back(x);
      wreg(3'd3, x);
    end
    upd_q.push_back({5'h1A, 48'h123401234567});
    ce_cnt = 0;
    wreg(3'd2, 32'h7);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("cmb%0d_rst", i), 64'(ped_rst),
          64'(i >= 1 && i <= 4));
      chk($sformatf("cmb%0d_upd", i), 64'(ped_upd),
          64'(i == 5));
      chk($sformatf("cmb%0d_ce", i), 64'(ce),
          64'(i >= 9 && i <= 11));
    end
    chk("cmb_idle_busy", 64'(busy), 64'(0));
    chk("cmb_ce_cnt", 64'(ce_cnt), 64'(3));

    // Overflow: 65 writes into a 64-word buffer.
    wreg(3'd2, 32'h8);
    for (int i = 0; i < 65; i++) begin
      x = $urandom;
      if (i < 64) dinl_q.push_back(x);
      wreg(3'd3, x);
    end
    rreg(3'd2, r);
    chk("ovf_status", 64'(r), 64'h4040);
    ce_cnt = 0;
    wreg(3'd2, 32'h4);
    run(70);
    chk("ovf_ce_cnt", 64'(ce_cnt), 64'(64));
    chk("ovf_q_empty", 64'(dinl_q.size()), 64'(0));

    // Duplicate PED_GO while the reset is running.
    wreg(3'd2, 32'h10);
    rreg(3'd2, r);
    chk("errclr_status", 64'(r), 64'h4000);
    upd_cnt = 0;
    upd_q.push_back({5'h1A, 48'h123401234567});
    wreg(3'd2, 32'h1);
    step();
    wreg(3'd2, 32'h2);
    wreg(3'd2, 32'h2);
    run(12);
    chk("dup_pulses", 64'(upd_cnt), 64'(1));
    rreg(3'd2, r);
    chk("dup_status", 64'(r), 64'h4020);
    wreg(3'd3, 32'hCAFEF00D);
    rreg(3'd2, r);
    chk("both_err_status", 64'(r), 64'h4060);
    wreg(3'd2, 32'h10);
    rreg(3'd2, r);
    chk("both_clr_status", 64'(r), 64'h4000);

    // DINL_DATA during playout is dropped; GO replays data.
    wreg(3'd2, 32'h8);
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      dinl_q.push_back(words[i]);
      wreg(3'd3, words[i]);
    end
    ce_cnt = 0;
    wreg(3'd2, 32'h4);
    step();
    wreg(3'd3, 32'hBAD0BAD0);
    run(8);
    chk("play_ce_cnt", 64'(ce_cnt), 64'(4));
    rreg(3'd2, r);
    chk("play_dup_status", 64'(r), 64'h0420);
    for (int i = 0; i < 4; i++) dinl_q.push_back(words[i]);
    ce_cnt = 0;
    wreg(3'd2, 32'h14);
    run(8);
    chk("replay_ce_cnt", 64'(ce_cnt), 64'(4));
    chk("replay_q_empty", 64'(dinl_q.size()), 64'(0));

    // Empty DINL command.
    wreg(3'd2, 32'h8);
    ce_cnt = 0;
    wreg(3'd2, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      if (!busy) break;
    end
    chk("empty_busy_low", 64'(busy), 64'(0));
    chk("empty_ce_cnt", 64'(ce_cnt), 64'(0));

    // Reset in the middle of a long playout.
    wreg(3'd2, 32'h8);
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      dinl_q.push_back(x);
      wreg(3'd3, x);
    end
    wreg(3'd2, 32'h4);
    run(3);
    chk("mid_ce_active", 64'(ce), 64'(1));
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    dinl_q.delete();
    step();
    chk("mid_rst_ce", 64'(ce), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ped", 64'(ped), 64'(0));
    rreg(3'd2, r);
    chk("mid_rst_status", 64'(r), 64'h0);
    run(4);
    chk("final_upd_q", 64'(upd_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
